// File: rtl/if_stage_fetch_if.sv
// Instruction-memory read channel between the fetch stage (master) and instruction memory (slave).
// One request is outstanding at a time; ack is a single-cycle completion pulse carrying rdata.
interface if_stage_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and loads the IF/ID register.
// Optional IF_FETCH_COUNT_EN adds a fetch_count port counting valid IF/ID loads.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  Branch_taken,
    input  logic [31:0]           BranchAddr,
    if_stage_fetch_if.master      imem,
    output logic                  IF_valid,
    output logic [31:0]           IF_Instruction,
    output logic [31:0]           IF_PC
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [31:0]           fetch_count
`endif
);

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_addr;

    assign next_addr = fetch_addr_q + 32'd4;

    // DRAIN keeps presenting the abandoned address until its ack retires the access.
    assign imem.imem_req  = ~rst & (state_q != StHold);
    assign imem.imem_addr = (state_q == StDrain) ? drain_addr_q : fetch_addr_q;

    assign IF_valid       = valid_q;
    assign IF_Instruction = instr_q;
    assign IF_PC          = pc_q;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        drain_addr_d = drain_addr_q;
        hold_buf_d   = hold_buf_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;

        if (Branch_taken) begin
            // Flush keeps IF_PC; the buffered word, if any, is dropped.
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            hold_buf_d   = NOP_INSTR;
            fetch_addr_d = BranchAddr;
            unique case (state_q)
                StFetch: begin
                    if (!imem.imem_ack) begin
                        state_d      = StDrain;
                        drain_addr_d = fetch_addr_q;
                    end
                end
                StHold:  state_d = StFetch;
                StDrain: begin
                    if (imem.imem_ack) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem.imem_ack) begin
                        if (freeze) begin
                            hold_buf_d = imem.imem_rdata;
                            state_d    = StHold;
                        end else begin
                            valid_d      = 1'b1;
                            instr_d      = imem.imem_rdata;
                            pc_d         = next_addr;
                            fetch_addr_d = next_addr;
                        end
                    end else if (!freeze) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                StHold: begin
                    if (!freeze) begin
                        valid_d      = 1'b1;
                        instr_d      = hold_buf_q;
                        pc_d         = next_addr;
                        fetch_addr_d = next_addr;
                        state_d      = StFetch;
                    end
                end
                StDrain: begin
                    if (imem.imem_ack) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFetch;
            fetch_addr_q <= RESET_PC;
            drain_addr_q <= RESET_PC;
            hold_buf_q   <= NOP_INSTR;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_q         <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            drain_addr_q <= drain_addr_d;
            hold_buf_q   <= hold_buf_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
        end
    end

`ifdef IF_FETCH_COUNT_EN
    logic [31:0] count_q;
    logic        load_valid;

    assign load_valid = ~Branch_taken & ~freeze &
                        (((state_q == StFetch) & imem.imem_ack) | (state_q == StHold));
    assign fetch_count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 32'h0000_0000;
        end else if (load_valid) begin
            count_q <= count_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Scoreboard bench for if_stage_fetch: stimulus pushes expected IF/ID loads, a monitor pops them.
module tb_if_stage_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        Branch_taken;
    logic [31:0] BranchAddr;
    logic        IF_valid;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
`ifdef IF_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int   checks;
    int   errors;
    exp_t sb[$];
    int   mem_wait;
    int   cnt;

    if_stage_fetch_if bus ();

    if_stage_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .Branch_taken   (Branch_taken),
        .BranchAddr     (BranchAddr),
        .imem           (bus),
        .IF_valid       (IF_valid),
        .IF_Instruction (IF_Instruction),
        .IF_PC          (IF_PC)
`ifdef IF_FETCH_COUNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: ack arrives mem_wait cycles after the request first appears.
    assign bus.imem_ack   = bus.imem_req && (cnt == mem_wait);
    assign bus.imem_rdata = bus.imem_ack ? word(bus.imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 0;
        else if (!bus.imem_req || bus.imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] addr);
        exp_t e;
        e.instr = word(addr);
        e.pc    = addr + 32'd4;
        sb.push_back(e);
    endtask

    task automatic wait_empty(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: a new IF/ID entry appears at every edge not held by freeze.
    initial begin
        logic frz;
        logic br;
        exp_t e;
        forever begin
            @(posedge clk);
            frz = freeze;
            br  = Branch_taken;
            #1;
            if (!rst && IF_valid && !(frz && !br)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got instr %h pc %h, required no load",
                             IF_Instruction, IF_PC);
                end else begin
                    e = sb.pop_front();
                    check("mon_instr", IF_Instruction, e.instr);
                    check("mon_pc", IF_PC, e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        freeze       = 1'b0;
        Branch_taken = 1'b0;
        BranchAddr   = 32'h0;
        mem_wait     = 0;
        #1 rst = 1'b1;
        #2;
        check("rst_valid", IF_valid, 0);
        check("rst_instr", IF_Instruction, 32'h0);
        check("rst_pc", IF_PC, 32'h0);
        check("rst_req", bus.imem_req, 0);
`ifdef IF_FETCH_COUNT_EN
        check("rst_count", fetch_count, 0);
`endif

        // Zero-wait streaming: one instruction per cycle.
        for (int a = 0; a < 16; a += 4) push(a);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t1_stream", sb.size(), 0);
`ifdef IF_FETCH_COUNT_EN
        check("t1_count", fetch_count, 4);
`endif
        sb.delete();
        rst = 1'b1;

        // Two-wait memory: two bubbles between loads.
        mem_wait = 2;
        for (int a = 0; a < 12; a += 4) push(a);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #2 check("t2_bubble1", IF_valid, 0);
        @(posedge clk);
        #2 check("t2_bubble2", IF_valid, 0);
        wait_empty(12, "t2_drain");
        rst = 1'b1;

        // Freeze across the ack of address 8.
        mem_wait = 0;
        for (int a = 0; a < 16; a += 4) push(a);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) freeze = 1'b1;
        @(posedge clk);
        #2;
        check("t3_hold_req", bus.imem_req, 0);
        check("t3_hold_instr", IF_Instruction, word(32'h4));
        check("t3_hold_pc", IF_PC, 32'h8);
        check("t3_hold_valid", IF_valid, 1);
        @(posedge clk);
        #2 check("t3_hold_req2", bus.imem_req, 0);
        @(posedge clk);
        @(negedge clk) freeze = 1'b0;
        wait_empty(6, "t3_release");
        rst = 1'b1;

        // Redirect while a request to 0x10 is pending.
        mem_wait = 0;
        for (int a = 0; a < 16; a += 4) push(a);
        push(32'h40);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        mem_wait     = 3;
        Branch_taken = 1'b1;
        BranchAddr   = 32'h40;
        @(posedge clk);
        #2;
        check("t4_flush_valid", IF_valid, 0);
        check("t4_flush_pc", IF_PC, 32'h10);
        check("t4_drain_req", bus.imem_req, 1);
        check("t4_drain_addr", bus.imem_addr, 32'h10);
        @(negedge clk) Branch_taken = 1'b0;
        @(posedge clk);
        #2 check("t4_drain_addr2", bus.imem_addr, 32'h10);
        wait_empty(20, "t4_redirect");
        rst = 1'b1;

        // Branch and freeze together: flush wins.
        mem_wait = 0;
        push(32'h0);
        push(32'h80);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        freeze       = 1'b1;
        Branch_taken = 1'b1;
        BranchAddr   = 32'h80;
        @(posedge clk);
        #2;
        check("t5_valid", IF_valid, 0);
        check("t5_instr", IF_Instruction, 32'h0);
        check("t5_pc", IF_PC, 32'h4);
        check("t5_addr", bus.imem_addr, 32'h80);
        @(negedge clk);
        freeze       = 1'b0;
        Branch_taken = 1'b0;
        wait_empty(6, "t5_resume");
        rst = 1'b1;

        // Asynchronous reset in the middle of a wait.
        mem_wait = 1;
        push(32'h0);
        @(negedge clk) rst = 1'b0;
        wait_empty(6, "t6_first");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_valid", IF_valid, 0);
        check("t6_instr", IF_Instruction, 32'h0);
        check("t6_pc", IF_PC, 32'h0);
        check("t6_req", bus.imem_req, 0);
`ifdef IF_FETCH_COUNT_EN
        check("t6_count", fetch_count, 0);
`endif
        push(32'h0);
        @(negedge clk) rst = 1'b0;
        #1;
        check("t6_req_after", bus.imem_req, 1);
        check("t6_addr_after", bus.imem_addr, 32'h0);
        wait_empty(6, "t6_refetch");
`ifdef IF_FETCH_COUNT_EN
        check("t6_count_after", fetch_count, 1);
`endif
        rst = 1'b1;

        #20;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
